// File: rtl/seconds_countdown_ctrl_pkg.sv
// Shared definitions for the seconds countdown controller and its display helpers.
// Holds the FSM state encoding, the two-digit BCD ceiling and default widths/limits.
package seconds_countdown_ctrl_pkg;

    localparam int unsigned BCD_MAX      = 99;
    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned WD_W_DEF     = 28;
    localparam int unsigned WD_LIMIT_DEF = 110_000_000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_HOLD    = 3'd4
    } state_e;

endpackage

// File: rtl/seconds_countdown_ctrl_if.sv
// Handshake between the countdown controller (initiator) and the 1-second one-shot timer.
//   tmr_start : 1-cycle arm strobe, initiator -> timer
//   tmr_done  : done level pulse (1..4 cycles), timer -> initiator
interface seconds_countdown_ctrl_if;

    logic tmr_start;
    logic tmr_done;

    modport master (output tmr_start, input tmr_done);
    modport slave  (input tmr_start, output tmr_done);

endinterface

// File: rtl/seconds_countdown_ctrl_bin2bcd_2digit.sv
// Combinational binary to two-digit BCD converter, usable by any 0..99 display.
// Inputs above 99 show as 99.
//   bin_i  : binary value
//   tens_c : tens digit
//   ones_c : ones digit
module bin2bcd_2digit
    import seconds_countdown_ctrl_pkg::*;
#(
    parameter int unsigned IN_W = 8
) (
    input  logic [IN_W-1:0] bin_i,
    output logic [3:0]      tens_c,
    output logic [3:0]      ones_c
);

    logic [IN_W-1:0] bin_sat;

    assign bin_sat = (bin_i > IN_W'(BCD_MAX)) ? IN_W'(BCD_MAX) : bin_i;
    assign tens_c  = 4'(bin_sat / IN_W'(10));
    assign ones_c  = 4'(bin_sat % IN_W'(10));

endmodule

// File: rtl/seconds_countdown_ctrl.sv
// Initiator side of the 1-second timer handshake: loads a seconds value, arms the
// one-shot timer, decrements once per completed second, re-arms until zero and then
// pulses expired. A watchdog flags a timer that never raises done.
//   clk, reset  : clock, synchronous active-high reset
//   load        : 1-cycle strobe, capture load_value (saturated to 99)
//   load_value  : seconds to count
//   pause       : level, hold at the next second boundary
//   tmr         : timer handshake (tmr_start out, tmr_done in)
//   secs_left   : remaining seconds, binary
//   bcd_tens/ones : remaining seconds, BCD (combinational from secs_left)
//   running     : high in ARM/WAIT_HI/WAIT_LO
//   expired     : 1-cycle pulse when the count reaches 0
//   timeout_err : sticky watchdog flag, cleared by reset or load
module seconds_countdown_ctrl
    import seconds_countdown_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned WD_W     = WD_W_DEF,
    parameter int unsigned WD_LIMIT = WD_LIMIT_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      load,
    input  logic [CNT_W-1:0]          load_value,
    input  logic                      pause,
    seconds_countdown_ctrl_if.master  tmr,
    output logic [CNT_W-1:0]          secs_left,
    output logic [3:0]                bcd_tens,
    output logic [3:0]                bcd_ones,
    output logic                      running,
    output logic                      expired,
    output logic                      timeout_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] secs_q, secs_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             tmr_start_q, tmr_start_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;
    logic             timeout_err_q, timeout_err_d;

    logic [CNT_W-1:0] load_sat;
    logic [WD_W-1:0]  wd_inc;

    assign load_sat = (load_value > CNT_W'(BCD_MAX)) ? CNT_W'(BCD_MAX) : load_value;
    // Watchdog value including the current WAIT_HI cycle.
    assign wd_inc   = wd_q + WD_W'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            secs_q        <= '0;
            wd_q          <= '0;
            tmr_start_q   <= 1'b0;
            running_q     <= 1'b0;
            expired_q     <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            secs_q        <= secs_d;
            wd_q          <= wd_d;
            tmr_start_q   <= tmr_start_d;
            running_q     <= running_d;
            expired_q     <= expired_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state, counter and watchdog logic.
    always_comb begin
        state_d       = state_q;
        secs_d        = secs_q;
        wd_d          = wd_q;
        expired_d     = 1'b0;
        timeout_err_d = timeout_err_q;

        if (load) begin
            // Load overrides everything, including a watchdog hit in the same cycle.
            secs_d        = load_sat;
            wd_d          = '0;
            timeout_err_d = 1'b0;
            if (load_sat == '0) begin
                expired_d = 1'b1;
                state_d   = ST_IDLE;
            end else if ((state_q != ST_IDLE) && tmr.tmr_done) begin
                // Timer still busy: wait for done to fall rather than arm it twice.
                state_d = ST_WAIT_LO;
            end else begin
                state_d = ST_ARM;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ARM: begin
                    wd_d    = '0;
                    state_d = ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tmr.tmr_done) begin
                        if (secs_q != '0) begin
                            secs_d = secs_q - CNT_W'(1);
                        end
                        state_d = ST_WAIT_LO;
                    end else if (wd_inc == WD_W'(WD_LIMIT)) begin
                        timeout_err_d = 1'b1;
                        state_d       = ST_IDLE;
                    end else begin
                        wd_d = wd_inc;
                    end
                end
                ST_WAIT_LO: begin
                    if (!tmr.tmr_done) begin
                        if (secs_q == '0) begin
                            expired_d = 1'b1;
                            state_d   = ST_IDLE;
                        end else if (pause) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_ARM;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!pause) begin
                        state_d = ST_ARM;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        tmr_start_d = (state_d == ST_ARM);
        running_d   = (state_d == ST_ARM) || (state_d == ST_WAIT_HI) || (state_d == ST_WAIT_LO);
    end

    // Display digits follow the registered count.
    bin2bcd_2digit #(
        .IN_W (CNT_W)
    ) u_bcd (
        .bin_i  (secs_q),
        .tens_c (bcd_tens),
        .ones_c (bcd_ones)
    );

    assign tmr.tmr_start = tmr_start_q;
    assign secs_left     = secs_q;
    assign running       = running_q;
    assign expired       = expired_q;
    assign timeout_err   = timeout_err_q;

endmodule

// File: tb/tb_seconds_countdown_ctrl.sv
// Self-checking bench for seconds_countdown_ctrl with a 10-cycle / 3-cycle-high timer model.
module tb_seconds_countdown_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = 8'd0;
    logic       pause = 1'b0;
    logic [7:0] secs_left;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_ones;
    logic       running;
    logic       expired;
    logic       timeout_err;

    seconds_countdown_ctrl_if tif ();

    seconds_countdown_ctrl #(
        .CNT_W    (8),
        .WD_W     (28),
        .WD_LIMIT (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .pause       (pause),
        .tmr         (tif),
        .secs_left   (secs_left),
        .bcd_tens    (bcd_tens),
        .bcd_ones    (bcd_ones),
        .running     (running),
        .expired     (expired),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Timer model: done high on cycles 10..12 after the cycle tmr_start is seen.
    int age = 0;
    bit tmr_en = 1'b1;
    always @(posedge clk) begin
        if (reset)                          age <= 0;
        else if (tif.tmr_start && tmr_en)   age <= 1;
        else if (age == 12)                 age <= 0;
        else if (age != 0)                  age <= age + 1;
    end
    assign tif.tmr_done = (age >= 10);

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_start = 0;
    int n_exp = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_chk++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (tif.tmr_start == 1'b1) n_start++;
        if (expired == 1'b1)       n_exp++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        pause = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic do_load(input int v);
        load_value = 8'(v);
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    // Follows a countdown from its first strobe to expiry: k-th strobe must show n-k+1.
    task automatic run_count(input string name, input int n_sec, input bit chk_period,
                             input bit rand_pause, input int budget);
        int seen   = 0;
        int bad    = 0;
        int last_c = -1;
        int k      = n_sec;
        bit fin    = 1'b0;
        for (int t = 0; t < budget; t++) begin
            if (tif.tmr_start == 1'b1) begin
                seen++;
                if (int'(secs_left) != k || int'(bcd_tens) != k / 10 || int'(bcd_ones) != k % 10)
                    bad++;
                if (chk_period && last_c >= 0 && cyc - last_c != 14) bad++;
                last_c = cyc;
                k--;
            end
            if (expired == 1'b1) begin
                fin = 1'b1;
                if (chk_period && cyc - last_c != 14) bad++;
                break;
            end
            if (rand_pause && $urandom_range(0, 7) == 0) pause = ~pause;
            tick();
        end
        pause = 1'b0;
        chk({name, " expiry seen"}, int'(fin), 1);
        chk({name, " strobes"}, seen, n_sec);
        chk({name, " seq errs"}, bad, 0);
        chk({name, " secs at expiry"}, int'(secs_left), 0);
        tick();
        chk({name, " idle after"}, int'({running, expired}), 0);
    endtask

    typedef struct {
        int v;
        int secs;
        int tens;
        int ones;
        int exp_p;
        int run;
    } vec_t;

    vec_t vtab[9];

    initial begin
        int k;
        int v;
        int sat;

        vtab[0] = '{0,   0,  0, 0, 1, 0};
        vtab[1] = '{1,   1,  0, 1, 0, 1};
        vtab[2] = '{9,   9,  0, 9, 0, 1};
        vtab[3] = '{10,  10, 1, 0, 0, 1};
        vtab[4] = '{42,  42, 4, 2, 0, 1};
        vtab[5] = '{99,  99, 9, 9, 0, 1};
        vtab[6] = '{100, 99, 9, 9, 0, 1};
        vtab[7] = '{150, 99, 9, 9, 0, 1};
        vtab[8] = '{255, 99, 9, 9, 0, 1};

        // Reset state, checked while reset is held.
        reset = 1'b1;
        tick();
        tick();
        chk("reset secs", int'(secs_left), 0);
        chk("reset bcd", int'({bcd_tens, bcd_ones}), 0);
        chk("reset flags", int'({tif.tmr_start, running, expired, timeout_err}), 0);
        reset = 1'b0;

        // Load table: first cycle after the load strobe.
        foreach (vtab[i]) begin
            do_reset();
            do_load(vtab[i].v);
            chk("tab secs", int'(secs_left), vtab[i].secs);
            chk("tab tens", int'(bcd_tens), vtab[i].tens);
            chk("tab ones", int'(bcd_ones), vtab[i].ones);
            chk("tab expired", int'(expired), vtab[i].exp_p);
            chk("tab running", int'(running), vtab[i].run);
            chk("tab tmr_start", int'(tif.tmr_start), vtab[i].run);
        end

        // 1) Three-second countdown with fixed 14-cycle re-arm period.
        do_reset();
        do_load(3);
        run_count("cnt3", 3, 1'b1, 1'b0, 200);

        // 2) Load 0 in IDLE, pause high to show it has no effect there.
        do_reset();
        pause = 1'b1;
        do_load(0);
        chk("zero expired", int'(expired), 1);
        n_start = 0;
        n_exp   = 0;
        repeat (20) tick();
        chk("zero no strobe", n_start, 0);
        chk("zero single pulse", n_exp, 0);
        chk("zero running", int'(running), 0);
        pause = 1'b0;

        // 3) Pause during the first second: stop at 1, no re-arm until released.
        do_reset();
        pause = 1'b1;
        do_load(2);
        chk("pause first strobe", int'(tif.tmr_start), 1);
        n_start = 0;
        n_exp   = 0;
        repeat (40) tick();
        chk("pause secs", int'(secs_left), 1);
        chk("pause not running", int'(running), 0);
        chk("pause no strobe", n_start, 0);
        chk("pause no expiry", n_exp, 0);
        pause = 1'b0;
        tick();
        run_count("pause rest", 1, 1'b1, 1'b0, 100);

        // 4) Silent timer: watchdog fires 21 cycles after the strobe.
        do_reset();
        tmr_en = 1'b0;
        do_load(5);
        k = 0;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (timeout_err == 1'b1) begin
                k = t;
                break;
            end
        end
        chk("wd latency", k, 21);
        chk("wd running", int'(running), 0);
        chk("wd secs kept", int'(secs_left), 5);
        repeat (5) tick();
        chk("wd sticky", int'(timeout_err), 1);
        do_load(0);
        chk("wd cleared by load", int'(timeout_err), 0);
        tmr_en = 1'b1;

        // 5) Reload while done is high: no arm until done falls.
        do_reset();
        do_load(5);
        k = 0;
        for (int t = 0; t < 30 && tif.tmr_done != 1'b1; t++) tick();
        chk("reload done seen", int'(tif.tmr_done), 1);
        do_load(42);
        chk("reload secs", int'(secs_left), 42);
        chk("reload bcd", int'({bcd_tens, bcd_ones}), 8'h42);
        chk("reload no strobe", int'(tif.tmr_start), 0);
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (tif.tmr_start == 1'b1) begin
                k = t;
                break;
            end
        end
        chk("reload rearm cycles", k, 3);
        chk("reload rearm secs", int'(secs_left), 42);

        // 6) Saturating load then reset in WAIT_HI.
        do_reset();
        do_load(150);
        chk("sat secs", int'(secs_left), 99);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        chk("midreset secs", int'(secs_left), 0);
        chk("midreset bcd", int'({bcd_tens, bcd_ones}), 0);
        chk("midreset flags", int'({tif.tmr_start, running, expired, timeout_err}), 0);
        reset = 1'b0;
        tick();

        // Random loads and random pause against the whole-second model.
        for (int r = 0; r < 6; r++) begin
            v   = int'($urandom_range(1, 120));
            sat = (v > 99) ? 99 : v;
            do_load(v);
            run_count("rand", sat, 1'b0, 1'b1, 6000);
            repeat (3) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global time limit: got no finish, expected finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
